seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle signed integer divider for the 8-bit ALU; companion (inverse operation) to the combinational signed multiplier.
- Shift-subtract restoring divider, one quotient bit per clock; start/busy/done handshake.
- Sign handling: convert operands to magnitudes, divide unsigned, fix signs at the end.
- Quotient truncates toward zero; remainder takes the dividend's sign.

Parameters:
WIDTH, 8, operand/result width in bits; iteration count equals WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset; asynchronous, active-high
start  input  1  request; sampled only when idle (busy=0)
dividend  input  WIDTH  two's-complement dividend, sampled with start
divisor  input  WIDTH  two's-complement divisor, sampled with start
quotient  output  WIDTH  registered quotient, held until next completion
remainder  output  WIDTH  registered remainder, held until next completion
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when quotient/remainder are updated
div_zero  output  1  divisor was 0 for the last completed operation
overflow  output  1  last result was not representable (MIN / -1)

Behaviour:
- Reset (async, active-high): quotient=0, remainder=0, busy=0, done=0, div_zero=0, overflow=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: on start=1 at edge E0, latch the magnitudes of both operands, the quotient sign (dividend MSB XOR divisor MSB) and the remainder sign (dividend MSB). Set busy=1.
    - Divisor==0: go to FIN.
    - Otherwise: go to CALC with counter=0.
  - CALC: WIDTH edges (E1..E8 for WIDTH=8).
    - Each edge: partial remainder (WIDTH+1 bits) = {rem, next dividend bit}; subtract the divisor magnitude.
    - Non-negative difference: keep it; shift in quotient bit 1. Negative: restore; shift in 0.
    - After the last iteration, go to SIGN.
  - SIGN (edge E9):
    - Negate the quotient magnitude if the quotient sign is set; negate the remainder magnitude if the remainder sign is set. Negation is two's complement mod 2^WIDTH.
    - Write the outputs; done=1 for one cycle; busy=0; div_zero=0.
    - overflow=1 iff the quotient magnitude is 2^(WIDTH-1) and the quotient sign is 0.
    - Return to IDLE.
  - FIN (divide-by-zero, edge E1): quotient=all ones, remainder=dividend as latched, div_zero=1, overflow=0, done=1, busy=0; return to IDLE.
- Latency: done high in the cycle after E9 (9 clocks after start is sampled); divide-by-zero completes in 1 clock.
- Magnitudes are unsigned WIDTH-bit, so |MIN| = 2^(WIDTH-1) is exact. MIN/1 gives MIN with overflow=0.
- start while busy=1: ignored, no queuing; operands may change freely while busy.
- start may be asserted in the same cycle done=1 (the controller is back in IDLE); a new operation begins at that edge.
- Outputs change only on completion edges; div_zero and overflow are cleared/overwritten on every completion.
- Reset mid-operation aborts immediately: no done pulse, outputs return to reset values.

Optional Feature:
- Macro SEQ_DIVIDER_UNSIGNED_EN.
- Defined: extra input port is_signed (1 bit), sampled with start.
  - is_signed=0: operands are used directly as unsigned; no negation in SIGN; overflow is always 0; divide-by-zero gives quotient=all ones, remainder=dividend.
  - is_signed=1: signed behaviour above.
- Undefined: port absent; the block is always signed.

Test Plan:
1. dividend=0x64 (100), divisor=0x07 -> done exactly 9 clocks after start; quotient=0x0E, remainder=0x02, div_zero=0, overflow=0.
2. Sign combinations:
   - 0x9C/0x07 (-100/7) -> q=0xF2, r=0xFE.
   - 0x64/0xF9 (100/-7) -> q=0xF2, r=0x02.
   - 0x9C/0xF9 -> q=0x0E, r=0xFE.
3. dividend=0x32, divisor=0x00 -> done 1 clock after start; q=0xFF, r=0x32, div_zero=1; a following 0x0A/0x02 gives q=0x05, r=0x00, div_zero=0.
4. Edge values:
   - 0x80/0xFF -> q=0x80, r=0x00, overflow=1.
   - 0x80/0x01 -> q=0x80, overflow=0.
   - 0x05/0x09 -> q=0x00, r=0x05.
5. Start 0x64/0x07, pulse start with 0x10/0x02 at clock 3 -> second request ignored; result q=0x0E. Start again in the done cycle with 0x10/0x02 -> q=0x08 nine clocks later.
6. Assert rst at clock 4 of an operation -> busy=0, done never pulses, q=r=0 immediately. With SEQ_DIVIDER_UNSIGNED_EN and is_signed=0: 0xC8/0x07 -> q=0x1C, r=0x04.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro SEQ_DIVIDER_UNSIGNED_EN adds an is_signed input selecting signed or unsigned operation.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN, FIN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] shift_q, shift_q_next;
    logic [WIDTH-1:0] dvs_mag, dvs_mag_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic             q_neg, q_neg_next;
    logic             r_neg, r_neg_next;
    logic             signed_op, signed_op_next;
    logic [WIDTH-1:0] quotient_next, remainder_next;
    logic             busy_next, done_next, div_zero_next, overflow_next;

    logic             use_signed;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   partial, diff;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    assign use_signed = is_signed;
`else
    assign use_signed = 1'b1;
`endif

    // shift_q starts as the dividend magnitude; its top bit feeds the partial
    // remainder while quotient bits enter at the bottom, so it ends holding the quotient.
    always_comb begin
        dvd_abs = (use_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs = (use_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        partial = {rem, shift_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_mag};
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        shift_q_next   = shift_q;
        dvs_mag_next   = dvs_mag;
        rem_next       = rem;
        q_neg_next     = q_neg;
        r_neg_next     = r_neg;
        signed_op_next = signed_op;
        quotient_next  = quotient;
        remainder_next = remainder;
        busy_next      = busy;
        done_next      = 1'b0;
        div_zero_next  = div_zero;
        overflow_next  = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    q_neg_next     = use_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_next     = use_signed & dividend[WIDTH-1];
                    signed_op_next = use_signed;
                    shift_q_next   = dvd_abs;
                    dvs_mag_next   = dvs_abs;
                    count_next     = '0;
                    busy_next      = 1'b1;
                    // On divide-by-zero the raw dividend parks in rem to become the remainder.
                    if (divisor == '0) begin
                        rem_next   = dividend;
                        state_next = FIN;
                    end else begin
                        rem_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_next     = diff[WIDTH-1:0];
                    shift_q_next = {shift_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next     = partial[WIDTH-1:0];
                    shift_q_next = {shift_q[WIDTH-2:0], 1'b0};
                end
                if (count == LAST) begin
                    count_next = '0;
                    state_next = SIGN;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            SIGN: begin
                quotient_next  = q_neg ? -shift_q : shift_q;
                remainder_next = r_neg ? -rem : rem;
                overflow_next  = signed_op && !q_neg && (shift_q == MIN_MAG);
                div_zero_next  = 1'b0;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
            FIN: begin
                quotient_next  = '1;
                remainder_next = rem;
                overflow_next  = 1'b0;
                div_zero_next  = 1'b1;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            shift_q   <= '0;
            dvs_mag   <= '0;
            rem       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            signed_op <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count     <= count_next;
            shift_q   <= shift_q_next;
            dvs_mag   <= dvs_mag_next;
            rem       <= rem_next;
            q_neg     <= q_neg_next;
            r_neg     <= r_neg_next;
            signed_op <= signed_op_next;
            quotient  <= quotient_next;
            remainder <= remainder_next;
            busy      <= busy_next;
            done      <= done_next;
            div_zero  <= div_zero_next;
            overflow  <= overflow_next;
        end
    end

endmodule
